// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with PC, 2-entry buffer and redirect
// Optional perf counters (fetch_count, flush_count) enabled by FETCH_PERF_CNT_EN.
module fetch_sequencer #(
    parameter int DEPTH    = 32,
    parameter int RESET_PC = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [1:0]    count_q, count_d;
    logic [AW-1:0] slot_pc_q [2];
    logic [31:0]   slot_instr_q [2];
    logic          push, pop;
    logic          unused_redirect_bits;

    // Only the low AW bits of the redirect target address the memory.
    assign unused_redirect_bits = ^redirect_pc[31:AW];

    assign imem_addr = {{(32-AW){1'b0}}, pc_q};
    assign out_valid = (count_q != 2'd0);
    assign out_instr = out_valid ? slot_instr_q[0] : 32'd0;
    assign out_pc    = out_valid ? {{(32-AW){1'b0}}, slot_pc_q[0]} : 32'd0;

    assign pop  = out_valid && out_ready && !redirect_valid;
    assign push = (state_q == ST_RUN) && !redirect_valid && ((count_q != 2'd2) || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_RUN;
            ST_RUN:   if (!run) state_d = ST_PAUSE;
            ST_PAUSE: if (run) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (redirect_valid) begin
            pc_d    = redirect_pc[AW-1:0];
            count_d = 2'd0;
        end else begin
            if (push) pc_d = pc_q + 1'b1;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= AW'(RESET_PC);
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Slot 0 is always the head; a pop shifts slot 1 forward.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_pc_q[0]    <= '0;
            slot_pc_q[1]    <= '0;
            slot_instr_q[0] <= '0;
            slot_instr_q[1] <= '0;
        end else if (!redirect_valid) begin
            if (pop) begin
                slot_pc_q[0]    <= slot_pc_q[1];
                slot_instr_q[0] <= slot_instr_q[1];
            end
            if (push) begin
                if ((count_q == 2'd0) || (pop && count_q == 2'd1)) begin
                    slot_pc_q[0]    <= pc_q;
                    slot_instr_q[0] <= imem_data;
                end else begin
                    slot_pc_q[1]    <= pc_q;
                    slot_instr_q[1] <= imem_data;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            if (push) fetch_count_q <= fetch_count_q + 32'd1;
            if (redirect_valid) flush_count_q <= flush_count_q + {30'd0, count_q};
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer (DEPTH=32, RESET_PC=0)
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, run, redirect_valid, out_ready;
    logic [31:0] imem_addr, imem_data, redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr, out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, flush_count;
`endif

    logic [31:0] mem [32];
    logic [63:0] sb_q [$];
    logic [4:0]  m_pc;
    int          m_state;
    logic [31:0] m_fetch, m_flush;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr[4:0]];

    fetch_sequencer #(.DEPTH(32), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare at negedge, then advance the reference model across the next posedge.
    task automatic tick();
        logic        pop, push;
        logic [63:0] head;
        @(negedge clk);
        check("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
        check("imem_addr", imem_addr, {27'd0, m_pc});
        if (sb_q.size() != 0) begin
            head = sb_q[0];
            check("out_pc", out_pc, head[63:32]);
            check("out_instr", out_instr, head[31:0]);
        end else begin
            check("out_pc_empty", out_pc, 32'd0);
            check("out_instr_empty", out_instr, 32'd0);
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, m_fetch);
        check("flush_count", flush_count, m_flush);
`endif
        pop  = (sb_q.size() != 0) && out_ready && !redirect_valid;
        push = (m_state == 1) && !redirect_valid && ((sb_q.size() < 2) || pop);
        if (reset) begin
            sb_q.delete();
            m_pc    = 5'd0;
            m_state = 0;
            m_fetch = 0;
            m_flush = 0;
        end else begin
            if (redirect_valid) begin
                m_flush = m_flush + sb_q.size();
                sb_q.delete();
                m_pc = redirect_pc[4:0];
            end else begin
                if (pop) void'(sb_q.pop_front());
                if (push) begin
                    sb_q.push_back({27'd0, m_pc, mem[m_pc]});
                    m_pc    = m_pc + 5'd1;
                    m_fetch = m_fetch + 32'd1;
                end
            end
            if (m_state == 0) m_state = run ? 1 : 0;
            else              m_state = run ? 1 : 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA500_0000;
        mem[5] = 32'd0;
        m_pc = 0; m_state = 0; m_fetch = 0; m_flush = 0;
        reset = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(4);
        run = 1'b1;
        ticks(6);
        out_ready = 1'b0;
        ticks(5);
        out_ready = 1'b1;
        ticks(4);
        out_ready = 1'b0;
        ticks(3);
        redirect_valid = 1'b1; redirect_pc = 32'd3;
        tick();
        redirect_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        ticks(3);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        ticks(6);
        run = 1'b0;
        ticks(3);
        run = 1'b1;
        ticks(2);
        out_ready = 1'b0;
        ticks(3);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd7;
        tick();
        reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        ticks(3);
        for (int i = 0; i < 300; i++) begin
            run            = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        ticks(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the word-indexed, combinational-read instruction memory. It owns the program counter and drives the memory address every cycle. Fetched words go into a 2-entry buffer that feeds decode through a valid/ready handshake. Execute can redirect it on a taken branch.

## Interface
- `DEPTH`, 32, instruction-memory depth in words; power of two, at least 2.
- `RESET_PC`, 0, word index loaded into the PC on reset; must be less than `DEPTH`.
- `clk`  in  1  clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  fetch enable; level-sensitive.
- `imem_addr`  out  32  word index presented to instruction memory; equals the PC, zero-extended.
- `imem_data`  in  32  word read from instruction memory; valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  taken-branch redirect request.
- `redirect_pc`  in  32  redirect target word index; only the low log2(`DEPTH`) bits are used.
- `out_valid`  out  1  buffer head holds an instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  instruction at the buffer head.
- `out_pc`  out  32  word index of `out_instr`, zero-extended.
- `fetch_count`  out  32  present only with `FETCH_PERF_CNT_EN`; see Configuration.
- `flush_count`  out  32  present only with `FETCH_PERF_CNT_EN`; see Configuration.

## Operation
- PC width is log2(`DEPTH`) bits. The increment wraps from `DEPTH`-1 to 0.
- States:
  - IDLE: entered on reset; no fetch.
  - RUN: fetch one word per cycle.
  - PAUSE: no fetch; the buffer keeps draining.
- Transitions:
  - IDLE→RUN when `run`=1.
  - RUN→PAUSE when `run`=0.
  - PAUSE→RUN when `run`=1.
  - No path returns to IDLE except `reset`.
- Fetch occurs in a cycle when all of the following hold:
  - the state is RUN;
  - `redirect_valid`=0;
  - the buffer has a free slot, or it is full and the head pops this cycle.
- On a fetch, {PC, `imem_data`} is pushed at the tail and the PC increments.
- Pop occurs when `out_valid`=1, `out_ready`=1 and `redirect_valid`=0.
- The buffer is a 2-entry FIFO with an occupancy count 0..2. Push and pop may happen in the same cycle, including when the buffer is full.
- Redirect, in any state including IDLE:
  - clears the buffer;
  - loads the masked `redirect_pc` into the PC;
  - suppresses any push or pop in that cycle.
  - Decode treats a head presented in a redirect cycle as squashed.
- Reset:
  - PC←`RESET_PC`, state←IDLE, occupancy←0, `out_valid`=0.
  - `out_instr` and `out_pc` are 0 while the buffer is empty.
  - Reset mid-operation discards buffer contents; reset overrides redirect.
- The word fetched is not decoded; zero words are buffered like any other.

## Timing
- `imem_addr` always equals the current PC register; it does not depend combinationally on any input.
- `run` sampled 1 in IDLE at cycle N:
  - RUN from N+1;
  - first fetch (of `RESET_PC`) in N+1;
  - `out_valid`=1 at N+2.
- Redirect at cycle N:
  - `out_valid`=0 at N+1;
  - fetch of the target in N+1;
  - target appears at the head at N+2.
- Steady state with `out_ready` held at 1: one instruction per cycle, consecutive PCs.
- `out_ready`=0: the buffer fills to 2, then the PC and `imem_addr` hold. The head stays stable until it is accepted.
- `run` falling at cycle N: the word fetched in N is still pushed; no fetch from N+1 on.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every push;
  - `flush_count` increments by the number of entries discarded by a redirect (0..2);
  - both reset to 0 and wrap at 2^32.
- `FETCH_PERF_CNT_EN` not defined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- Reset, then hold `run`=0 for 4 cycles: `out_valid`=0, `imem_addr`=0 and the state stays IDLE throughout.
- `run`=1 at cycle 0 with `out_ready`=1: `out_pc`=0,1,2,3 on cycles 2..5, and `out_instr` equals the memory contents at each.
- `out_ready`=0 for 5 cycles after the stream starts: occupancy reaches 2 and `imem_addr` freezes. Releasing `out_ready` delivers the held PCs in order with no gap or duplicate.
- `redirect_valid`=1 with `redirect_pc`=3 while the buffer is full: `out_valid`=0 the next cycle, `out_pc`=3 two cycles later; with the macro defined, `flush_count` increases by 2.
- Start fetching at PC 30 with `DEPTH`=32: `out_pc` sequence is 30, 31, 0, 1.
- Assert `reset` while RUN with the buffer full: `out_valid`=0 next cycle, PC=`RESET_PC`, state IDLE; with the macro defined, both counters are 0.
